// File: rtl/wb_rr_intercon.sv
// Purpose: round-robin multi-master / multi-slave Wishbone shared bus with address decode and bus-error generation.
// Latency: 1-cycle registered arbitration; address, data and ack/err are forwarded combinationally once granted.
// Backpressure: masters wait on ack/err; unmapped accesses and slaves hung past TIMEOUT receive an interconnect err.
module wb_rr_intercon #(
  parameter int MASTERS_NUM = 2,
  parameter int SLAVES_NUM  = 3,
  parameter int ADR_WIDTH   = 32,
  parameter int DAT_WIDTH   = 32,
  parameter int SEL_WIDTH   = 4,
  parameter logic [SLAVES_NUM*ADR_WIDTH-1:0] SLAVE_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [SLAVES_NUM*ADR_WIDTH-1:0] SLAVE_MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
  parameter int TIMEOUT     = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [MASTERS_NUM-1:0]         m2i_cyc_i,
  input  logic [MASTERS_NUM-1:0]         m2i_stb_i,
  input  logic [MASTERS_NUM-1:0]         m2i_we_i,
  input  logic [MASTERS_NUM*ADR_WIDTH-1:0] m2i_adr_i,
  input  logic [MASTERS_NUM*DAT_WIDTH-1:0] m2i_dat_i,
  input  logic [MASTERS_NUM*SEL_WIDTH-1:0] m2i_sel_i,
  output logic [MASTERS_NUM-1:0]         i2m_ack_o,
  output logic [MASTERS_NUM-1:0]         i2m_err_o,
  output logic [DAT_WIDTH-1:0]           i2m_dat_o,
  input  logic [SLAVES_NUM-1:0]          s2i_ack_i,
  input  logic [SLAVES_NUM-1:0]          s2i_err_i,
  input  logic [SLAVES_NUM*DAT_WIDTH-1:0] s2i_dat_i,
  output logic [SLAVES_NUM-1:0]          i2s_stb_o,
  output logic                           i2s_cyc_o,
  output logic [ADR_WIDTH-1:0]           i2s_adr_o,
  output logic [DAT_WIDTH-1:0]           i2s_dat_o,
  output logic [SEL_WIDTH-1:0]           i2s_sel_o,
  output logic                           i2s_we_o,
  output logic [MASTERS_NUM-1:0]         grant_o
);

  localparam int MW = (MASTERS_NUM > 1) ? $clog2(MASTERS_NUM) : 1;
  localparam int SW = (SLAVES_NUM > 1) ? $clog2(SLAVES_NUM) : 1;

  typedef enum logic {ST_IDLE, ST_GRANTED} state_t;

  state_t          state;
  logic [MW-1:0]   grant_idx;
  logic [MW-1:0]   rr_ptr;
  logic [7:0]      wd_cnt;
  logic            err_pend;
  logic            miss_seen;

  logic [MW-1:0]   next_idx;
  logic [MW-1:0]   cand;
  logic            req_found;
  logic            hit_any;
  logic [SW-1:0]   hit_idx;
  logic            granted, access, s_ack, s_err, wd_fire;

  // Unpacked views of the packed buses so the muxes index by grant/decode result.
  logic [ADR_WIDTH-1:0] m_adr_a [MASTERS_NUM];
  logic [DAT_WIDTH-1:0] m_dat_a [MASTERS_NUM];
  logic [SEL_WIDTH-1:0] m_sel_a [MASTERS_NUM];
  logic [DAT_WIDTH-1:0] s_dat_a [SLAVES_NUM];

  for (genvar i = 0; i < MASTERS_NUM; i++) begin : g_mst
    assign m_adr_a[i] = m2i_adr_i[i*ADR_WIDTH +: ADR_WIDTH];
    assign m_dat_a[i] = m2i_dat_i[i*DAT_WIDTH +: DAT_WIDTH];
    assign m_sel_a[i] = m2i_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
  end

  for (genvar j = 0; j < SLAVES_NUM; j++) begin : g_slv
    assign s_dat_a[j] = s2i_dat_i[j*DAT_WIDTH +: DAT_WIDTH];
  end

  logic                 m_cyc, m_stb, m_we;
  logic [ADR_WIDTH-1:0] m_adr;

  assign granted = (state == ST_GRANTED);
  assign m_cyc   = m2i_cyc_i[grant_idx];
  assign m_stb   = m2i_stb_i[grant_idx];
  assign m_we    = m2i_we_i[grant_idx];
  assign m_adr   = m_adr_a[grant_idx];

  // Round-robin search: first requester after the last owner, wrapping.
  always_comb begin
    next_idx  = rr_ptr;
    cand      = rr_ptr;
    req_found = 1'b0;
    for (int k = 1; k <= MASTERS_NUM; k++) begin
      cand = MW'((int'(rr_ptr) + k) % MASTERS_NUM);
      if (!req_found && m2i_cyc_i[cand]) begin
        req_found = 1'b1;
        next_idx  = cand;
      end
    end
  end

  // Address decode; scanning downwards lets the lowest matching slave win.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int j = SLAVES_NUM - 1; j >= 0; j--) begin
      if ((m_adr & SLAVE_MASK[j*ADR_WIDTH +: ADR_WIDTH]) ==
          (SLAVE_BASE[j*ADR_WIDTH +: ADR_WIDTH] & SLAVE_MASK[j*ADR_WIDTH +: ADR_WIDTH])) begin
        hit_any = 1'b1;
        hit_idx = SW'(j);
      end
    end
  end

  assign access  = granted & m_cyc & m_stb;
  assign s_ack   = access & hit_any & s2i_ack_i[hit_idx];
  assign s_err   = access & hit_any & s2i_err_i[hit_idx];
  // A slave response in the timeout cycle takes priority over the watchdog.
  assign wd_fire = access & hit_any & ~s_ack & ~s_err & (wd_cnt == 8'(TIMEOUT - 1));

  assign i2s_cyc_o = granted & m_cyc;
  assign i2s_we_o  = granted & m_we;
  assign i2s_adr_o = granted ? m_adr : '0;
  assign i2s_dat_o = granted ? m_dat_a[grant_idx] : '0;
  assign i2s_sel_o = granted ? m_sel_a[grant_idx] : '0;
  assign i2s_stb_o = (access & hit_any) ? (SLAVES_NUM'(1) << hit_idx) : '0;
  assign i2m_dat_o = (access & hit_any) ? s_dat_a[hit_idx] : '0;

  // grant_o is zero outside GRANTED, so it doubles as the response steering mask.
  assign i2m_ack_o = (s_ack & ~s_err) ? grant_o : '0;
  assign i2m_err_o = (granted & (s_err | wd_fire | err_pend)) ? grant_o : '0;

  // Arbitration FSM with watchdog and unmapped-address error tracking.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      grant_o   <= '0;
      rr_ptr    <= MW'(MASTERS_NUM - 1);
      wd_cnt    <= 8'd0;
      err_pend  <= 1'b0;
      miss_seen <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wd_cnt    <= 8'd0;
          err_pend  <= 1'b0;
          miss_seen <= 1'b0;
          if (req_found) begin
            state     <= ST_GRANTED;
            grant_idx <= next_idx;
            grant_o   <= MASTERS_NUM'(1) << next_idx;
          end
        end
        ST_GRANTED: begin
          if (!m_cyc) begin
            state     <= ST_IDLE;
            rr_ptr    <= grant_idx;
            grant_o   <= '0;
            wd_cnt    <= 8'd0;
            err_pend  <= 1'b0;
            miss_seen <= 1'b0;
          end else begin
            // One err pulse per held miss strobe; miss_seen stays set until stb drops.
            err_pend  <= access & ~hit_any & ~miss_seen;
            miss_seen <= access & ~hit_any;
            wd_cnt    <= (access & hit_any & ~s_ack & ~s_err & ~wd_fire) ? wd_cnt + 8'd1 : 8'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_intercon.sv
// Purpose: self-checking bench for wb_rr_intercon with two masters and three modelled slaves.
// Latency: expected responses and grant order are queued when stimulus is driven and popped on DUT output.
// Backpressure: slave models ack after a programmable wait, can hang, or raise err together with ack.
module tb_wb_rr_intercon;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [1:0]   m_cyc, m_stb, m_we;
  logic [63:0]  m_adr, m_dat;
  logic [7:0]   m_sel;
  logic [1:0]   i2m_ack, i2m_err;
  logic [31:0]  i2m_dat;
  logic [2:0]   s_ack, s_err;
  logic [95:0]  s_dat;
  logic [2:0]   i2s_stb;
  logic         i2s_cyc, i2s_we;
  logic [31:0]  i2s_adr, i2s_dat;
  logic [3:0]   i2s_sel;
  logic [1:0]   grant;

  always #5 clk = ~clk;

  wb_rr_intercon #(
    .MASTERS_NUM(2), .SLAVES_NUM(3), .ADR_WIDTH(32), .DAT_WIDTH(32), .SEL_WIDTH(4),
    .SLAVE_BASE({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLAVE_MASK({32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
    .TIMEOUT(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m2i_cyc_i(m_cyc), .m2i_stb_i(m_stb), .m2i_we_i(m_we),
    .m2i_adr_i(m_adr), .m2i_dat_i(m_dat), .m2i_sel_i(m_sel),
    .i2m_ack_o(i2m_ack), .i2m_err_o(i2m_err), .i2m_dat_o(i2m_dat),
    .s2i_ack_i(s_ack), .s2i_err_i(s_err), .s2i_dat_i(s_dat),
    .i2s_stb_o(i2s_stb), .i2s_cyc_o(i2s_cyc), .i2s_adr_o(i2s_adr),
    .i2s_dat_o(i2s_dat), .i2s_sel_o(i2s_sel), .i2s_we_o(i2s_we),
    .grant_o(grant)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave models: respond once the strobe has been held lat[j] cycles.
  int         lat [3];
  int         wcnt [3];
  logic [2:0] never, errboth, resp;

  assign s_dat = {32'hCAFE_0002, 32'hDEAD_BEEF, 32'h0000_1110};
  assign s_ack = resp;
  assign s_err = resp & errboth;

  always_comb begin
    resp = '0;
    for (int j = 0; j < 3; j++)
      resp[j] = i2s_stb[j] && !never[j] && (wcnt[j] >= lat[j]);
  end

  always @(posedge clk) begin
    for (int j = 0; j < 3; j++)
      wcnt[j] <= (!i2s_stb[j] || resp[j]) ? 0 : wcnt[j] + 1;
  end

  // Response scoreboard, one queue per master.
  typedef struct { bit is_err; logic [31:0] dat; int ncyc; } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];

  // Grant-order scoreboard; gap < 0 means the idle gap is not checked.
  typedef struct { int idx; int gap; } gexp_t;
  gexp_t      gq[$];
  gexp_t      ge;
  bit         gm_en = 1'b0;
  int         idle_run = 0;
  logic [1:0] prev_grant = '0;

  always @(negedge clk) begin
    if (rst_i === 1'b1 && gm_en) begin
      if (grant == 2'b00) idle_run++;
      else if (grant != prev_grant) begin
        check_val("grant_expected", 64'(gq.size() != 0), 64'd1);
        if (gq.size() != 0) begin
          ge = gq.pop_front();
          check_val("grant_order", 64'(grant), 64'd1 << ge.idx);
          if (ge.gap >= 0) check_val("grant_gap", 64'(idle_run), 64'(ge.gap));
        end
        idle_run = 0;
      end
    end
    prev_grant = grant;
  end

  task automatic do_xfer(input int m, input logic [31:0] adr, input logic we, input logic [31:0] wd,
                         input bit exp_err, input logic [31:0] exp_dat, input int exp_ncyc,
                         input int hold, output logic [2:0] stb_seen);
    exp_t e;
    exp_t got_e;
    int   n;
    bit   seen;
    e.is_err = exp_err; e.dat = exp_dat; e.ncyc = exp_ncyc;
    if (m == 0) sb0.push_back(e); else sb1.push_back(e);
    m_adr[m*32 +: 32] = adr;
    m_dat[m*32 +: 32] = wd;
    m_sel[m*4 +: 4]   = 4'hF;
    m_we[m]  = we;
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    n = 0; seen = 1'b0; stb_seen = '0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (grant[m] && i2s_cyc) begin
        n++;
        stb_seen |= i2s_stb;
      end
      if (i2m_ack[m] || i2m_err[m]) seen = 1'b1;
    end
    check_val("resp_seen", 64'(seen), 64'd1);
    if (seen) begin
      check_val("sb_nonempty", 64'((m == 0) ? sb0.size() != 0 : sb1.size() != 0), 64'd1);
      got_e = (m == 0) ? sb0.pop_front() : sb1.pop_front();
      check_val("resp_err", 64'(i2m_err[m]), 64'(got_e.is_err));
      check_val("resp_ack", 64'(i2m_ack[m]), 64'(!got_e.is_err));
      if (!got_e.is_err && !we) check_val("resp_dat", 64'(i2m_dat), 64'(got_e.dat));
      check_val("resp_ncyc", 64'(n), 64'(got_e.ncyc));
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_val("err_norepeat", 64'({i2m_ack[m], i2m_err[m]}), 64'd0);
    end
    @(posedge clk); #1;
    m_stb[m] = 1'b0;
    m_cyc[m] = 1'b0;
    m_we[m]  = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  logic [2:0] ss0, ss1;
  bit         seen_g;

  initial begin
    rst_i = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    lat[0] = 1; lat[1] = 0; lat[2] = 0;
    never = '0; errboth = '0;

    // Reset with every master requesting
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); @(negedge clk);
      check_val("rst_grant", 64'(grant), 64'd0);
      check_val("rst_stb", 64'(i2s_stb), 64'd0);
      check_val("rst_cyc", 64'(i2s_cyc), 64'd0);
      check_val("rst_ack", 64'(i2m_ack), 64'd0);
      check_val("rst_err", 64'(i2m_err), 64'd0);
    end
    @(posedge clk); #1;
    rst_i = 1'b1; m_cyc = '0; m_stb = '0;
    @(posedge clk); #1;

    // Decode: slave 1 read
    do_xfer(1, 32'h1000_0004, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 1, 0, ss0);
    check_val("dec_stb_onehot", 64'(ss0), 64'b010);

    // Round-robin fairness, last owner m1 so m0 goes first
    idle_run = 0;
    gq.push_back('{0, -1});
    for (int i = 0; i < 5; i++) gq.push_back('{(i % 2 == 0) ? 1 : 0, 1});
    gm_en = 1'b1;
    fork
      for (int i = 0; i < 3; i++) do_xfer(0, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 32'h0000_1110, 2, 0, ss0);
      for (int i = 0; i < 3; i++) do_xfer(1, 32'h0000_0020, 1'b0, 32'h0, 1'b0, 32'h0000_1110, 2, 0, ss1);
    join
    gm_en = 1'b0;
    check_val("grant_seq_left", 64'(gq.size()), 64'd0);

    // Unmapped address: delayed single err, no strobe, no repeat while stb held
    do_xfer(0, 32'hF000_0000, 1'b0, 32'h0, 1'b1, 32'h0, 2, 2, ss0);
    check_val("unmapped_stb", 64'(ss0), 64'd0);

    // Slave err with ack in the same cycle: err only
    errboth[1] = 1'b1;
    do_xfer(0, 32'h1000_0000, 1'b0, 32'h0, 1'b1, 32'h0, 1, 0, ss0);
    errboth[1] = 1'b0;

    // Watchdog: hung slave errs on the 8th wait cycle; ack on that cycle wins
    never[2] = 1'b1;
    do_xfer(1, 32'h2000_0000, 1'b0, 32'h0, 1'b1, 32'h0, 8, 0, ss1);
    never[2] = 1'b0;
    lat[2] = 7;
    do_xfer(0, 32'h2000_0008, 1'b0, 32'h0, 1'b0, 32'hCAFE_0002, 8, 0, ss0);

    // Write forwarding, then reset in the middle of the m1 write
    never[0] = 1'b1;
    m_adr[32 +: 32] = 32'h0000_0040;
    m_dat[32 +: 32] = 32'h1234_5678;
    m_sel[4 +: 4]   = 4'h3;
    m_we[1] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    seen_g = 1'b0;
    for (int c = 0; c < 10 && !seen_g; c++) begin
      @(negedge clk);
      if (grant[1]) seen_g = 1'b1;
    end
    check_val("wr_granted", 64'(seen_g), 64'd1);
    check_val("wr_adr", 64'(i2s_adr), 64'h40);
    check_val("wr_dat", 64'(i2s_dat), 64'h1234_5678);
    check_val("wr_sel", 64'(i2s_sel), 64'h3);
    check_val("wr_we", 64'(i2s_we), 64'd1);
    check_val("wr_stb", 64'(i2s_stb), 64'b001);
    @(posedge clk); #1;
    rst_i = 1'b0;
    m_adr[0 +: 32] = 32'h0; m_we[0] = 1'b0; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    check_val("mr_cyc_dropped", 64'(i2s_cyc), 64'd0);
    check_val("mr_grant_cleared", 64'(grant), 64'd0);
    @(negedge clk);
    check_val("mr_first_grant", 64'(grant), 64'b01);
    @(posedge clk); #1;
    m_cyc = '0; m_stb = '0; m_we = '0;
    never = '0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
